// File: rtl/bus_decode.sv
// Address decoder and cycle terminator for the 68030 bus: chip selects, internally
// timed DSACK for ROM/IO, autovector, reset-time ROM overlay and bus-error watchdog.
module bus_decode #(
    parameter int ROM_WAIT     = 3,
    parameter int IO_WAIT      = 5,
    parameter int BERR_TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        nAS,
    input  logic        RnW,
    input  logic [2:0]  FC,
    input  logic [15:0] ADDR,
    output logic        DRAM_nCS,
    output logic        ROM_nCS,
    output logic [3:0]  IO_nCS,
    output logic        DSACK0,
    output logic        DSACK1,
    output logic        BERR,
    output logic        AVEC,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [2:0] C_DRAM = 3'd0;
    localparam logic [2:0] C_ROM  = 3'd1;
    localparam logic [2:0] C_IO   = 3'd2;
    localparam logic [2:0] C_IACK = 3'd3;
    localparam logic [2:0] C_BAD  = 3'd4;

    localparam logic [3:0] ROM_W    = 4'(ROM_WAIT);
    localparam logic [3:0] IO_W     = 4'(IO_WAIT);
    localparam logic [7:0] WD_LIMIT = 8'(BERR_TIMEOUT - 1);

    logic [1:0] state;
    logic [3:0] wcnt;
    logic [7:0] wdcnt;
    logic       overlay;
    logic       rom_fe_q;
    logic       io_q;

    logic [2:0] cls;
    logic       rom_fe;
    logic       active;

    // Write direction and A23..A20 play no part in decoding.
    logic unused_inputs;
    assign unused_inputs = ^{RnW, ADDR[7:4]};

    // ADDR carries A31..A16, so A[n] lives at ADDR[n-16].
    always_comb begin
        cls    = C_BAD;
        rom_fe = 1'b0;
        if (FC == 3'd7) begin
            cls = (ADDR[3:0] == 4'hF) ? C_IACK : C_BAD;
        end else if (overlay && ADDR[15:8] == 8'h00) begin
            cls = C_ROM;
        end else if (ADDR[15:12] == 4'h0) begin
            cls = C_DRAM;
        end else if (ADDR[15:8] == 8'hFE) begin
            cls    = C_ROM;
            rom_fe = 1'b1;
        end else if (ADDR[15:8] == 8'hFF) begin
            cls = C_IO;
        end
    end

    assign active   = ~nAS & nRST;
    assign DRAM_nCS = ~(active && cls == C_DRAM);
    assign ROM_nCS  = ~(active && cls == C_ROM);
    assign IO_nCS   = (active && cls == C_IO) ? ~(4'b0001 << ADDR[1:0]) : 4'hF;
    assign dbg_state = state;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= S_IDLE;
            wcnt     <= 4'd0;
            wdcnt    <= 8'd0;
            overlay  <= 1'b1;
            rom_fe_q <= 1'b0;
            io_q     <= 1'b0;
            DSACK0   <= 1'b0;
            DSACK1   <= 1'b0;
            BERR     <= 1'b0;
            AVEC     <= 1'b0;
        end else begin
            if (nAS) begin
                wdcnt <= 8'd0;
            end else if (wdcnt != 8'hFF) begin
                wdcnt <= wdcnt + 8'd1;
            end

            case (state)
                S_IDLE: begin
                    if (!nAS) begin
                        rom_fe_q <= rom_fe;
                        io_q     <= (cls == C_IO);
                        case (cls)
                            C_ROM: begin
                                if (ROM_W == 4'd0) begin
                                    DSACK0 <= 1'b1;
                                    DSACK1 <= 1'b1;
                                    state  <= S_ACK;
                                end else begin
                                    wcnt  <= ROM_W;
                                    state <= S_WAIT;
                                end
                            end
                            C_IO: begin
                                if (IO_W == 4'd0) begin
                                    DSACK0 <= 1'b1;
                                    DSACK1 <= 1'b0;
                                    state  <= S_ACK;
                                end else begin
                                    wcnt  <= IO_W;
                                    state <= S_WAIT;
                                end
                            end
                            C_DRAM: state <= S_HOLD;
                            C_IACK: begin
                                AVEC  <= 1'b1;
                                state <= S_HOLD;
                            end
                            default: begin
                                BERR  <= 1'b1;
                                state <= S_HOLD;
                            end
                        endcase
                    end
                end
                S_WAIT: begin
                    if (nAS) begin
                        // Aborted cycle: the ROM-at-FE access still counts as having ended.
                        state <= S_IDLE;
                        wcnt  <= 4'd0;
                        BERR  <= 1'b0;
                        AVEC  <= 1'b0;
                        if (rom_fe_q) overlay <= 1'b0;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                        if (wcnt == 4'd1) begin
                            DSACK0 <= 1'b1;
                            DSACK1 <= ~io_q;
                            state  <= S_ACK;
                        end
                    end
                end
                default: begin
                    if (nAS) begin
                        state  <= S_IDLE;
                        wcnt   <= 4'd0;
                        DSACK0 <= 1'b0;
                        DSACK1 <= 1'b0;
                        BERR   <= 1'b0;
                        AVEC   <= 1'b0;
                        if (rom_fe_q) overlay <= 1'b0;
                    end
                end
            endcase

            // Watchdog overrides whatever the state machine is doing.
            if (!nAS && wdcnt == WD_LIMIT) begin
                BERR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_decode.sv
// Self-checking bench for bus_decode: directed cases from the bring-up plan plus
// randomized cycles scored against a decode/timing model of the bus rules.
module tb_bus_decode;

    localparam int ROM_W = 3;
    localparam int IO_W  = 5;
    localparam int BT    = 64;

    localparam int C_DRAM = 0;
    localparam int C_ROM  = 1;
    localparam int C_IO   = 2;
    localparam int C_IACK = 3;
    localparam int C_BAD  = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        nAS = 1'b1;
    logic        RnW = 1'b1;
    logic [2:0]  FC = 3'd6;
    logic [15:0] ADDR = 16'h0000;
    logic        DRAM_nCS, ROM_nCS, DSACK0, DSACK1, BERR, AVEC;
    logic [3:0]  IO_nCS;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    bit overlay_m = 1'b1;

    bus_decode #(.ROM_WAIT(ROM_W), .IO_WAIT(IO_W), .BERR_TIMEOUT(BT)) dut (
        .CLK(CLK), .nRST(nRST), .nAS(nAS), .RnW(RnW), .FC(FC), .ADDR(ADDR),
        .DRAM_nCS(DRAM_nCS), .ROM_nCS(ROM_nCS), .IO_nCS(IO_nCS),
        .DSACK0(DSACK0), .DSACK1(DSACK1), .BERR(BERR), .AVEC(AVEC),
        .dbg_state(dbg_state)
    );

    always #20 CLK = ~CLK;

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode on the full 32-bit address.
    function automatic int decode(input logic [2:0] fc, input logic [31:0] a, input bit ov);
        if (fc == 3'd7) return (a[19:16] == 4'hF) ? C_IACK : C_BAD;
        if (ov && a[31:24] == 8'h00) return C_ROM;
        if (a[31:28] == 4'h0) return C_DRAM;
        if (a[31:24] == 8'hFE) return C_ROM;
        if (a[31:24] == 8'hFF) return C_IO;
        return C_BAD;
    endfunction

    function automatic logic [5:0] exp_sel(input int c, input logic [31:0] a);
        logic [3:0] io;
        io = 4'hF;
        if (c == C_IO) io[a[17:16]] = 1'b0;
        return {c != C_DRAM, c != C_ROM, io};
    endfunction

    // One bus cycle with nAS held low for 'hold' edges; hold below the wait aborts.
    task automatic do_cycle(input string tag, input logic [2:0] fc, input logic [31:0] a,
                            input logic rnw, input int hold);
        int c;
        int wt;
        bit ds;
        logic [3:0] exp_t;
        c  = decode(fc, a, overlay_m);
        wt = (c == C_ROM) ? ROM_W : (c == C_IO) ? IO_W : 0;
        @(negedge CLK);
        FC = fc; ADDR = a[31:16]; RnW = rnw; nAS = 1'b0;
        #1;
        chk({tag, "_sel"}, {26'd0, DRAM_nCS, ROM_nCS, IO_nCS}, {26'd0, exp_sel(c, a)});
        for (int j = 0; j < hold; j++) begin
            @(posedge CLK);
            #1;
            ds = (c == C_ROM || c == C_IO) && j >= wt;
            exp_t = {ds, ds && c == C_ROM, c == C_BAD || j >= BT - 1, c == C_IACK};
            chk($sformatf("%s_term%0d", tag, j), {28'd0, DSACK0, DSACK1, BERR, AVEC}, {28'd0, exp_t});
        end
        @(negedge CLK);
        nAS = 1'b1;
        #1;
        chk({tag, "_sel_off"}, {26'd0, DRAM_nCS, ROM_nCS, IO_nCS}, 32'h3F);
        @(posedge CLK);
        #1;
        chk({tag, "_end"}, {26'd0, dbg_state, DSACK0, DSACK1, BERR, AVEC}, 32'h0);
        if (c == C_ROM && a[31:24] == 8'hFE && fc != 3'd7) overlay_m = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  fc;
        int c, hold;

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_state", {26'd0, dbg_state, DSACK0, DSACK1, BERR, AVEC}, 32'h0);
        chk("reset_sel", {26'd0, DRAM_nCS, ROM_nCS, IO_nCS}, 32'h3F);
        @(negedge CLK);
        nRST = 1'b1;

        do_cycle("ovl_rom", 3'd6, 32'h0000_0000, 1'b1, ROM_W + 2);
        do_cycle("fe_rom", 3'd6, 32'hFE00_0004, 1'b1, ROM_W + 1);
        do_cycle("dram_after", 3'd5, 32'h0000_0000, 1'b1, 4);
        do_cycle("io_wr", 3'd5, 32'hFF02_0000, 1'b0, IO_W + 2);
        do_cycle("bad_80", 3'd5, 32'h8000_0000, 1'b1, 2);
        do_cycle("wd_dram", 3'd5, 32'h0100_0000, 1'b1, 70);
        do_cycle("iack", 3'd7, 32'hFFFF_0000, 1'b1, 2);
        do_cycle("fc7_bad", 3'd7, 32'h0002_0000, 1'b1, 2);
        do_cycle("io_abort", 3'd5, 32'hFF01_0000, 1'b1, 2);
        do_cycle("io_dev3", 3'd1, 32'hFF03_1234, 1'b1, IO_W + 1);

        for (int n = 0; n < 40; n++) begin
            a  = $urandom;
            fc = 3'($urandom_range(0, 6));
            case ($urandom_range(0, 5))
                0: a[31:24] = 8'h00;
                1: a[31:28] = 4'h0;
                2: a[31:24] = 8'hFE;
                3: a[31:24] = 8'hFF;
                4: fc = 3'd7;
                default: ;
            endcase
            if (fc == 3'd7 && $urandom_range(0, 1) == 1) a[19:16] = 4'hF;
            c = decode(fc, a, overlay_m);
            hold = (c == C_ROM) ? ROM_W + 1 : (c == C_IO) ? IO_W + 1 : 1;
            hold += $urandom_range(0, 3);
            do_cycle($sformatf("rnd%0d", n), fc, a, 1'($urandom_range(0, 1)), hold);
        end

        // Reset in the middle of an I/O wait.
        @(negedge CLK);
        FC = 3'd5; ADDR = 16'hFF00; nAS = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        chk("rst_mid_sel", {26'd0, DRAM_nCS, ROM_nCS, IO_nCS}, 32'h3F);
        @(posedge CLK);
        #1;
        chk("rst_mid_state", {26'd0, dbg_state, DSACK0, DSACK1, BERR, AVEC}, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        nAS = 1'b1;
        overlay_m = 1'b1;
        do_cycle("ovl_again", 3'd6, 32'h0000_0010, 1'b1, ROM_W + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
